// File: rtl/id_rm_issue_pkg.sv
// Shared constants and types for the RM issue stage: instruction field
// encodings, enable levels, zero values and the issue FSM state type.
package id_rm_issue_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [XLEN-1:0]    ZERO     = {XLEN{1'b0}};
  localparam logic [RADDR_W-1:0] ZERO_REG = {RADDR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MDU_REQ = 1'b1
  } state_t;

endpackage

// File: rtl/id_rm_issue_decode.sv
// Combinational class decode for register-register instructions: splits
// ALU and MDU classes, flags everything else as illegal, and extracts the
// register fields.
module rm_decode
  import id_rm_issue_pkg::*;
(
  input  logic [31:0]        inst,
  output logic               is_alu,
  output logic               is_mdu,
  output logic               is_illegal,
  output logic [RADDR_W-1:0] rs1,
  output logic [RADDR_W-1:0] rs2,
  output logic [RADDR_W-1:0] rd
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign funct7_s = inst[31:25];
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];

  // Classify the instruction; anything not ALU or MDU is illegal.
  always_comb begin
    is_alu = DISABLE;
    is_mdu = DISABLE;
    if (opcode_s == OPCODE_OP) begin
      case (funct7_s)
        FUNCT7_BASE:   is_alu = ENABLE;
        FUNCT7_ALT: begin
          if ((funct3_s == FUNCT3_ADD_SUB) || (funct3_s == FUNCT3_SRL_SRA)) begin
            is_alu = ENABLE;
          end else begin
            is_alu = DISABLE;
          end
        end
        FUNCT7_MULDIV: is_mdu = ENABLE;
        default: begin
          is_alu = DISABLE;
          is_mdu = DISABLE;
        end
      endcase
    end else begin
      is_alu = DISABLE;
      is_mdu = DISABLE;
    end
    is_illegal = ~(is_alu | is_mdu);
  end

endmodule

// File: rtl/id_rm_issue.sv
// Issue stage for register-register ops: reads operands, issues ALU ops
// for one cycle, hands MDU ops off through a valid/ready request and tracks
// the outstanding MDU destination in a single-entry scoreboard.
module id_rm_issue
  import id_rm_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid_in,
  input  logic [31:0]        inst_in,
  output logic               inst_ready_out,
  output logic [RADDR_W-1:0] reg1_raddr_out,
  output logic [RADDR_W-1:0] reg2_raddr_out,
  output logic               reg1_renable_out,
  output logic               reg2_renable_out,
  input  logic [XLEN-1:0]    reg1_rdata_in,
  input  logic [XLEN-1:0]    reg2_rdata_in,
  output logic               ex_valid_out,
  output logic [XLEN-1:0]    op1_out,
  output logic [XLEN-1:0]    op2_out,
  output logic [2:0]         funct3_out,
  output logic               alt_out,
  output logic [RADDR_W-1:0] reg_waddr_out,
  output logic               reg_wenable_out,
  output logic               mdu_valid_out,
  input  logic               mdu_ready_in,
  input  logic               mdu_done_in,
  input  logic               flush_in,
  output logic               illegal_out
);

  state_t               state_r, state_n;
  logic                 sb_valid_r, sb_valid_n;
  logic [RADDR_W-1:0]   sb_rd_r, sb_rd_n;
  logic                 ex_valid_r, ex_valid_n;
  logic                 mdu_valid_r, mdu_valid_n;
  logic                 illegal_r, illegal_n;
  logic [XLEN-1:0]      op1_r, op1_n, op2_r, op2_n;
  logic [2:0]           funct3_r, funct3_n;
  logic                 alt_r, alt_n;
  logic [RADDR_W-1:0]   waddr_r, waddr_n;
  logic                 wenable_r, wenable_n;

  logic                 is_alu_s, is_mdu_s, is_illegal_s;
  logic [RADDR_W-1:0]   rs1_s, rs2_s, rd_s;
  logic                 hazard_s, accept_s;

  rm_decode u_decode (
    .inst       (inst_in),
    .is_alu     (is_alu_s),
    .is_mdu     (is_mdu_s),
    .is_illegal (is_illegal_s),
    .rs1        (rs1_s),
    .rs2        (rs2_s),
    .rd         (rd_s)
  );

  // x0 never matches because sb_rd of zero is excluded; MDU ops serialise.
  assign hazard_s = (sb_valid_r && (sb_rd_r != ZERO_REG) &&
                     ((rs1_s == sb_rd_r) || (rs2_s == sb_rd_r) || (rd_s == sb_rd_r))) ||
                    (is_mdu_s && sb_valid_r);

  assign inst_ready_out = (state_r == ST_IDLE) && !flush_in && !hazard_s && !rst;
  assign accept_s       = inst_valid_in && inst_ready_out;

  // Register-file read ports follow the presented instruction.
  always_comb begin
    if (inst_valid_in) begin
      reg1_raddr_out   = rs1_s;
      reg2_raddr_out   = rs2_s;
      reg1_renable_out = ENABLE;
      reg2_renable_out = ENABLE;
    end else begin
      reg1_raddr_out   = ZERO_REG;
      reg2_raddr_out   = ZERO_REG;
      reg1_renable_out = DISABLE;
      reg2_renable_out = DISABLE;
    end
  end

  // Next-state, scoreboard and issue-register logic.
  always_comb begin
    state_n     = state_r;
    sb_valid_n  = sb_valid_r;
    sb_rd_n     = sb_rd_r;
    ex_valid_n  = DISABLE;
    mdu_valid_n = mdu_valid_r;
    illegal_n   = DISABLE;
    op1_n       = op1_r;
    op2_n       = op2_r;
    funct3_n    = funct3_r;
    alt_n       = alt_r;
    waddr_n     = waddr_r;
    wenable_n   = wenable_r;

    // Completion only matters while an op is tracked.
    if (mdu_done_in && sb_valid_r) begin
      sb_valid_n = DISABLE;
    end else begin
      sb_valid_n = sb_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_illegal_s) begin
            illegal_n = ENABLE;
          end else begin
            op1_n     = reg1_rdata_in;
            op2_n     = reg2_rdata_in;
            funct3_n  = inst_in[14:12];
            alt_n     = inst_in[30];
            waddr_n   = rd_s;
            wenable_n = (rd_s != ZERO_REG);
            if (is_mdu_s) begin
              mdu_valid_n = ENABLE;
              state_n     = ST_MDU_REQ;
            end else begin
              ex_valid_n = ENABLE;
            end
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MDU_REQ: begin
        // A completed handshake wins over flush: the MDU owns the op now.
        if (mdu_ready_in) begin
          sb_valid_n  = ENABLE;
          sb_rd_n     = waddr_r;
          mdu_valid_n = DISABLE;
          state_n     = ST_IDLE;
        end else if (flush_in) begin
          mdu_valid_n = DISABLE;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_MDU_REQ;
        end
      end
      default: begin
        mdu_valid_n = DISABLE;
        state_n     = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Scoreboard and registered issue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_r  <= DISABLE;
      sb_rd_r     <= ZERO_REG;
      ex_valid_r  <= DISABLE;
      mdu_valid_r <= DISABLE;
      illegal_r   <= DISABLE;
      op1_r       <= ZERO;
      op2_r       <= ZERO;
      funct3_r    <= 3'b000;
      alt_r       <= DISABLE;
      waddr_r     <= ZERO_REG;
      wenable_r   <= DISABLE;
    end else begin
      sb_valid_r  <= sb_valid_n;
      sb_rd_r     <= sb_rd_n;
      ex_valid_r  <= ex_valid_n;
      mdu_valid_r <= mdu_valid_n;
      illegal_r   <= illegal_n;
      op1_r       <= op1_n;
      op2_r       <= op2_n;
      funct3_r    <= funct3_n;
      alt_r       <= alt_n;
      waddr_r     <= waddr_n;
      wenable_r   <= wenable_n;
    end
  end

  assign ex_valid_out    = ex_valid_r;
  assign mdu_valid_out   = mdu_valid_r;
  assign illegal_out     = illegal_r;
  assign op1_out         = op1_r;
  assign op2_out         = op2_r;
  assign funct3_out      = funct3_r;
  assign alt_out         = alt_r;
  assign reg_waddr_out   = waddr_r;
  assign reg_wenable_out = wenable_r;

endmodule

// File: tb/tb_id_rm_issue.sv
// Directed bench for id_rm_issue: ALU issue, MDU handshake, scoreboard
// stalls, illegal decode, flush and reset behaviour.
module tb_id_rm_issue;

  logic        clk;
  logic        rst;
  logic        inst_valid_in;
  logic [31:0] inst_in;
  logic        inst_ready_out;
  logic [4:0]  reg1_raddr_out, reg2_raddr_out;
  logic        reg1_renable_out, reg2_renable_out;
  logic [31:0] reg1_rdata_in, reg2_rdata_in;
  logic        ex_valid_out;
  logic [31:0] op1_out, op2_out;
  logic [2:0]  funct3_out;
  logic        alt_out;
  logic [4:0]  reg_waddr_out;
  logic        reg_wenable_out;
  logic        mdu_valid_out;
  logic        mdu_ready_in;
  logic        mdu_done_in;
  logic        flush_in;
  logic        illegal_out;

  int n_pass = 0;
  int n_total = 0;

  id_rm_issue dut (
    .clk              (clk),
    .rst              (rst),
    .inst_valid_in    (inst_valid_in),
    .inst_in          (inst_in),
    .inst_ready_out   (inst_ready_out),
    .reg1_raddr_out   (reg1_raddr_out),
    .reg2_raddr_out   (reg2_raddr_out),
    .reg1_renable_out (reg1_renable_out),
    .reg2_renable_out (reg2_renable_out),
    .reg1_rdata_in    (reg1_rdata_in),
    .reg2_rdata_in    (reg2_rdata_in),
    .ex_valid_out     (ex_valid_out),
    .op1_out          (op1_out),
    .op2_out          (op2_out),
    .funct3_out       (funct3_out),
    .alt_out          (alt_out),
    .reg_waddr_out    (reg_waddr_out),
    .reg_wenable_out  (reg_wenable_out),
    .mdu_valid_out    (mdu_valid_out),
    .mdu_ready_in     (mdu_ready_in),
    .mdu_done_in      (mdu_done_in),
    .flush_in         (flush_in),
    .illegal_out      (illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] d1, input logic [31:0] d2);
    inst_valid_in = 1'b1;
    inst_in       = inst;
    reg1_rdata_in = d1;
    reg2_rdata_in = d2;
    #1;
  endtask

  task automatic idle_in();
    inst_valid_in = 1'b0;
    inst_in       = 32'h0000_0000;
    #1;
  endtask

  initial begin
    rst = 1'b1; inst_valid_in = 1'b0; inst_in = 32'h0; reg1_rdata_in = 32'h0;
    reg2_rdata_in = 32'h0; mdu_ready_in = 1'b0; mdu_done_in = 1'b0; flush_in = 1'b0;

    // Reset values
    tick();
    check("rst_ex_valid", ex_valid_out, 32'd0);
    check("rst_mdu_valid", mdu_valid_out, 32'd0);
    check("rst_illegal", illegal_out, 32'd0);
    check("rst_op1", op1_out, 32'd0);
    check("rst_waddr", reg_waddr_out, 32'd0);
    check("rst_wenable", reg_wenable_out, 32'd0);
    check("rst_renable", reg1_renable_out, 32'd0);
    rst = 1'b0;
    #1;

    // ADD x3,x1,x2 with x1=5, x2=7
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
    check("add_raddr1", reg1_raddr_out, 32'd1);
    check("add_raddr2", reg2_raddr_out, 32'd2);
    check("add_renable2", reg2_renable_out, 32'd1);
    check("add_ready", inst_ready_out, 32'd1);
    tick(); idle_in();
    check("add_ex_valid", ex_valid_out, 32'd1);
    check("add_op1", op1_out, 32'd5);
    check("add_op2", op2_out, 32'd7);
    check("add_waddr", reg_waddr_out, 32'd3);
    check("add_wenable", reg_wenable_out, 32'd1);
    check("idle_raddr1", reg1_raddr_out, 32'd0);
    tick();
    check("add_ex_one_cycle", ex_valid_out, 32'd0);

    // MUL x4,x1,x2 with MDU not ready for 3 cycles
    present(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4), 32'd5, 32'd7);
    check("mul_ready", inst_ready_out, 32'd1);
    tick(); idle_in();
    check("mul_no_ex", ex_valid_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mul_valid_held", mdu_valid_out, 32'd1);
      check("mul_inst_ready_low", inst_ready_out, 32'd0);
      check("mul_op1_held", op1_out, 32'd5);
      tick();
    end
    check("mul_valid_still", mdu_valid_out, 32'd1);
    mdu_ready_in = 1'b1;
    tick();
    mdu_ready_in = 1'b0;
    check("mul_valid_dropped", mdu_valid_out, 32'd0);

    // Scoreboard holds x4: dependent ADD stalls, independent ADD would not
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd6), 32'd5, 32'd7);
    check("indep_no_stall", inst_ready_out, 32'd1);
    present(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd7), 32'd5, 32'd7);
    check("mdu_serialise_stall", inst_ready_out, 32'd0);
    present(rtype(7'b0000000, 5'd2, 5'd4, 3'b000, 5'd9), 32'd11, 32'd7);
    check("raw_rs1_stall", inst_ready_out, 32'd0);
    present(rtype(7'b0000000, 5'd1, 5'd4, 3'b000, 5'd5), 32'd11, 32'd5);
    check("raw_stall", inst_ready_out, 32'd0);
    tick();
    check("raw_stall_no_ex", ex_valid_out, 32'd0);
    check("raw_stall_still", inst_ready_out, 32'd0);
    mdu_done_in = 1'b1;
    #1;
    check("done_cycle_stall", inst_ready_out, 32'd0);
    tick();
    mdu_done_in = 1'b0;
    #1;
    check("after_done_ready", inst_ready_out, 32'd1);
    tick(); idle_in();
    check("dep_add_ex", ex_valid_out, 32'd1);
    check("dep_add_op1", op1_out, 32'd11);
    check("dep_add_op2", op2_out, 32'd5);
    check("dep_add_waddr", reg_waddr_out, 32'd5);
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd6), 32'd5, 32'd7);
    check("add6_ready", inst_ready_out, 32'd1);
    tick(); idle_in();
    check("add6_ex", ex_valid_out, 32'd1);
    check("add6_waddr", reg_waddr_out, 32'd6);

    // Illegal: funct7=0100000 with funct3=001
    present(rtype(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd8), 32'd1, 32'd2);
    tick(); idle_in();
    check("illegal_pulse", illegal_out, 32'd1);
    check("illegal_no_ex", ex_valid_out, 32'd0);
    check("illegal_no_mdu", mdu_valid_out, 32'd0);
    tick();
    check("illegal_one_cycle", illegal_out, 32'd0);
    present(32'h0000_0013, 32'd1, 32'd2);
    tick(); idle_in();
    check("illegal_opcode", illegal_out, 32'd1);

    // SUB x9,x1,x2 (alternate ALU encoding)
    present(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd9), 32'd9, 32'd3);
    tick(); idle_in();
    check("sub_ex", ex_valid_out, 32'd1);
    check("sub_alt", alt_out, 32'd1);
    check("sub_no_illegal", illegal_out, 32'd0);
    // SRL funct3=101 with funct3 captured
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd9), 32'd9, 32'd3);
    tick(); idle_in();
    check("srl_funct3", funct3_out, 32'd5);
    check("srl_alt", alt_out, 32'd0);

    // Flush during MDU_REQ without ready: request dropped, no scoreboard entry
    present(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd10), 32'd3, 32'd4);
    tick(); idle_in();
    flush_in = 1'b1;
    #1;
    check("flush_ready_low", inst_ready_out, 32'd0);
    tick();
    flush_in = 1'b0;
    #1;
    check("flush_mdu_dropped", mdu_valid_out, 32'd0);
    present(rtype(7'b0000000, 5'd1, 5'd10, 3'b000, 5'd11), 32'd0, 32'd5);
    check("flush_no_sb", inst_ready_out, 32'd1);
    idle_in();

    // Flush beats acceptance
    flush_in = 1'b1;
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
    check("flush_blocks_ready", inst_ready_out, 32'd0);
    tick(); idle_in();
    flush_in = 1'b0;
    check("flush_no_issue", ex_valid_out, 32'd0);

    // Flush coincident with mdu_ready: handshake completes, scoreboard set
    present(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd12), 32'd3, 32'd4);
    tick(); idle_in();
    flush_in = 1'b1; mdu_ready_in = 1'b1;
    tick();
    flush_in = 1'b0; mdu_ready_in = 1'b0;
    #1;
    check("flush_hs_mdu_low", mdu_valid_out, 32'd0);
    present(rtype(7'b0000000, 5'd1, 5'd12, 3'b000, 5'd13), 32'd0, 32'd5);
    check("flush_hs_sb_set", inst_ready_out, 32'd0);
    mdu_done_in = 1'b1;
    tick();
    mdu_done_in = 1'b0;
    idle_in();
    check("flush_hs_sb_cleared", inst_ready_out, 32'd1);

    // ADD x0,x1,x2: issues without write enable
    present(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7);
    tick(); idle_in();
    check("x0_ex", ex_valid_out, 32'd1);
    check("x0_wenable", reg_wenable_out, 32'd0);
    check("x0_op1", op1_out, 32'd5);

    // Asynchronous reset in MDU_REQ
    present(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4), 32'd6, 32'd8);
    tick(); idle_in();
    check("pre_rst_mdu_valid", mdu_valid_out, 32'd1);
    check("pre_rst_op2", op2_out, 32'd8);
    rst = 1'b1;
    #1;
    check("arst_mdu_valid", mdu_valid_out, 32'd0);
    check("arst_op1", op1_out, 32'd0);
    check("arst_op2", op2_out, 32'd0);
    check("arst_waddr", reg_waddr_out, 32'd0);
    check("arst_wenable", reg_wenable_out, 32'd0);
    check("arst_ex_valid", ex_valid_out, 32'd0);
    check("arst_ready", inst_ready_out, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", inst_ready_out, 32'd1);
    check("post_rst_mdu", mdu_valid_out, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
